// File: rtl/param_fifo.sv
// Parametrised single-clock FIFO with selectable registered or first-word-fall-through
// read, registered almost-full/almost-empty thresholds, sticky error flags and flush.
module param_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FWFT       = 0,
  parameter int AFULL_TH   = (2 ** ADDR_WIDTH) - 2,
  parameter int AEMPTY_TH  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_ena,
  input  logic [DATA_WIDTH-1:0] wr_dat,
  output logic                  wr_full,
  output logic                  almost_full,
  input  logic                  rd_ena,
  output logic [DATA_WIDTH-1:0] rd_dat,
  output logic                  rd_empty,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   dat_cnt,
  output logic                  ovf,
  output logic                  udf
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH + 1)'(AFULL_TH);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH + 1)'(AEMPTY_TH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH:0]   cnt_nxt;
  logic                  wr_acc;
  logic                  rd_acc;

  // A write into a full FIFO is still accepted when the same edge pops a word.
  assign rd_acc = rd_ena & ~rd_empty;
  assign wr_acc = wr_ena & (~wr_full | rd_acc);

  always_comb begin
    cnt_nxt = dat_cnt;
    if (wr_acc && !rd_acc) begin
      cnt_nxt = dat_cnt + 1'b1;
    end else if (rd_acc && !wr_acc) begin
      cnt_nxt = dat_cnt - 1'b1;
    end
  end

  // Flags are derived from the post-update count so they stay registered.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      dat_cnt      <= '0;
      rd_empty     <= 1'b1;
      wr_full      <= 1'b0;
      almost_full  <= ('0 >= AF_C);
      almost_empty <= 1'b1;
      ovf          <= 1'b0;
      udf          <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      dat_cnt      <= cnt_nxt;
      rd_empty     <= (cnt_nxt == '0);
      wr_full      <= (cnt_nxt == DEPTH_C);
      almost_full  <= (cnt_nxt >= AF_C);
      almost_empty <= (cnt_nxt <= AE_C);
      ovf          <= ovf | (wr_ena & ~wr_acc);
      udf          <= udf | (rd_ena & rd_empty);
    end
  end

  // Storage has no reset; flush leaves contents in place.
  always_ff @(posedge clk) begin
    if (!rst && !clr && wr_acc) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign rd_dat = mem[rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] rd_dat_q;
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          rd_dat_q <= '0;
        end else if (rd_acc) begin
          rd_dat_q <= mem[rd_ptr];
        end
      end
      assign rd_dat = rd_dat_q;
    end
  endgenerate

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: a standard-read and an FWFT instance share one stimulus stream
// and are checked against a queue model every cycle plus directed literal expectations.
module tb_param_fifo;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          wr_ena = 1'b0;
  logic [DW-1:0] wr_dat = '0;
  logic          rd_ena = 1'b0;

  logic          f0_full, f0_af, f0_empty, f0_ae, f0_ovf, f0_udf;
  logic [DW-1:0] f0_rd_dat;
  logic [AW:0]   f0_cnt;
  logic          f1_full, f1_af, f1_empty, f1_ae, f1_ovf, f1_udf;
  logic [DW-1:0] f1_rd_dat;
  logic [AW:0]   f1_cnt;

  param_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0), .AFULL_TH(14), .AEMPTY_TH(1)) dut_std (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_ena(wr_ena), .wr_dat(wr_dat), .wr_full(f0_full), .almost_full(f0_af),
    .rd_ena(rd_ena), .rd_dat(f0_rd_dat), .rd_empty(f0_empty), .almost_empty(f0_ae),
    .dat_cnt(f0_cnt), .ovf(f0_ovf), .udf(f0_udf)
  );

  param_fifo #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1), .AFULL_TH(14), .AEMPTY_TH(1)) dut_fwft (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_ena(wr_ena), .wr_dat(wr_dat), .wr_full(f1_full), .almost_full(f1_af),
    .rd_ena(rd_ena), .rd_dat(f1_rd_dat), .rd_empty(f1_empty), .almost_empty(f1_ae),
    .dat_cnt(f1_cnt), .ovf(f1_ovf), .udf(f1_udf)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: contents as a queue, read word and sticky errors as plain variables.
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_rd  = '0;
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;

  task automatic model_step();
    bit rd_ok, wr_ok;
    if (rst || clr) begin
      q.delete();
      m_rd  = '0;
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      rd_ok = rd_ena && (q.size() != 0);
      wr_ok = wr_ena && ((q.size() < DEPTH) || rd_ok);
      if (rd_ena && !rd_ok) m_udf = 1'b1;
      if (wr_ena && !wr_ok) m_ovf = 1'b1;
      if (rd_ok) m_rd = q.pop_front();
      if (wr_ok) q.push_back(wr_dat);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      int sz;
      sz = q.size();
      chk("std.dat_cnt", 32'(f0_cnt), 32'(sz));
      chk("std.rd_empty", 32'(f0_empty), 32'(sz == 0));
      chk("std.wr_full", 32'(f0_full), 32'(sz == DEPTH));
      chk("std.almost_full", 32'(f0_af), 32'(sz >= 14));
      chk("std.almost_empty", 32'(f0_ae), 32'(sz <= 1));
      chk("std.ovf", 32'(f0_ovf), 32'(m_ovf));
      chk("std.udf", 32'(f0_udf), 32'(m_udf));
      chk("std.rd_dat", 32'(f0_rd_dat), 32'(m_rd));
      chk("fwft.dat_cnt", 32'(f1_cnt), 32'(sz));
      chk("fwft.rd_empty", 32'(f1_empty), 32'(sz == 0));
      chk("fwft.wr_full", 32'(f1_full), 32'(sz == DEPTH));
      chk("fwft.almost_full", 32'(f1_af), 32'(sz >= 14));
      chk("fwft.almost_empty", 32'(f1_ae), 32'(sz <= 1));
      chk("fwft.ovf", 32'(f1_ovf), 32'(m_ovf));
      chk("fwft.udf", 32'(f1_udf), 32'(m_udf));
      if (sz != 0) chk("fwft.rd_dat", 32'(f1_rd_dat), 32'(q[0]));
    end
  end

  // Drive one cycle of inputs, wait for the edge, leave the outputs settled for sampling.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c = 1'b0,
                      input bit rs = 1'b0);
    wr_ena = w;
    wr_dat = d;
    rd_ena = r;
    clr    = c;
    rst    = rs;
    @(posedge clk);
    #2;
    wr_ena = 1'b0;
    rd_ena = 1'b0;
    clr    = 1'b0;
    rst    = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [DW-1:0] wrap_exp [12];

  initial begin
    wrap_exp = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4, 8'd1, 8'd2, 8'd3, 8'd4};

    // Reset state
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cmp_on = 1'b1;
    chk("rst.dat_cnt", 32'(f0_cnt), 32'd0);
    chk("rst.rd_empty", 32'(f0_empty), 32'd1);
    chk("rst.wr_full", 32'(f0_full), 32'd0);
    chk("rst.almost_empty", 32'(f0_ae), 32'd1);
    chk("rst.almost_full", 32'(f0_af), 32'd0);
    chk("rst.ovf_udf", 32'({f0_ovf, f0_udf}), 32'd0);
    chk("rst.rd_dat", 32'(f0_rd_dat), 32'd0);

    // Fill and drain
    for (int i = 0; i < 20; i++) begin
      step(1'b1, DW'(i), 1'b0);
      if (i == 12) chk("fill.af_13", 32'(f0_af), 32'd0);
      if (i == 13) chk("fill.af_14", 32'(f0_af), 32'd1);
      if (i == 14) chk("fill.full_15", 32'(f0_full), 32'd0);
      if (i == 15) begin
        chk("fill.full_16", 32'(f0_full), 32'd1);
        chk("fill.cnt_16", 32'(f0_cnt), 32'd16);
      end
    end
    chk("fill.ovf", 32'(f0_ovf), 32'd1);
    chk("fill.cnt_end", 32'(f0_cnt), 32'd16);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, '0, 1'b1);
      if (i < 16) chk("drain.rd_dat", 32'(f0_rd_dat), 32'(i));
      if (i == 13) chk("drain.ae_cnt2", 32'(f0_ae), 32'd0);
      if (i == 14) chk("drain.ae_cnt1", 32'(f0_ae), 32'd1);
    end
    chk("drain.empty", 32'(f0_empty), 32'd1);
    chk("drain.udf", 32'(f0_udf), 32'd1);
    chk("drain.rd_dat_hold", 32'(f0_rd_dat), 32'd15);

    // Wrap-around
    step(1'b0, '0, 1'b0, 1'b1);
    for (int rnd = 0; rnd < 3; rnd++) begin
      for (int k = 1; k <= 4; k++) step(1'b1, DW'(k), 1'b0);
      for (int k = 0; k < 3; k++) begin
        step(1'b0, '0, 1'b1);
        chk("wrap.rd_dat", 32'(f0_rd_dat), 32'(wrap_exp[rnd * 3 + k]));
      end
    end
    chk("wrap.cnt", 32'(f0_cnt), 32'd3);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, '0, 1'b1);
      chk("wrap.tail_rd_dat", 32'(f0_rd_dat), (k < 3) ? 32'(wrap_exp[9 + k]) : 32'd4);
    end
    chk("wrap.udf", 32'(f0_udf), 32'd1);

    // Simultaneous access at count 1 and at full
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 8'd9, 1'b0);
    for (int k = 0; k < 100; k++) step(1'b1, 8'd9, 1'b1);
    chk("simul.cnt1", 32'(f0_cnt), 32'd1);
    chk("simul.rd_dat", 32'(f0_rd_dat), 32'd9);
    chk("simul.ovf_udf", 32'({f0_ovf, f0_udf}), 32'd0);
    step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) step(1'b1, DW'(8'h40 + k), 1'b0);
    for (int k = 0; k < 100; k++) step(1'b1, DW'(k), 1'b1);
    chk("simul.cnt16", 32'(f0_cnt), 32'd16);
    chk("simul.full_ovf", 32'({f0_full, f0_ovf}), 32'b10);

    // Almost-full rise and fall
    step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 14; k++) begin
      step(1'b1, DW'(k), 1'b0);
      chk("thr.af_rise", 32'(f0_af), 32'(k == 13));
    end
    step(1'b0, '0, 1'b1);
    chk("thr.af_fall", 32'(f0_af), 32'd0);

    // First-word-fall-through
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 8'hA5, 1'b0);
    chk("fwft.empty_after_push", 32'(f1_empty), 32'd0);
    chk("fwft.head_a5", 32'(f1_rd_dat), 32'hA5);
    step(1'b1, 8'h3C, 1'b0);
    chk("fwft.head_still_a5", 32'(f1_rd_dat), 32'hA5);
    step(1'b0, '0, 1'b1);
    chk("fwft.head_3c", 32'(f1_rd_dat), 32'h3C);
    chk("std.pop_a5", 32'(f0_rd_dat), 32'hA5);

    // Flush with a concurrent write, then reset during a write
    step(1'b0, '0, 1'b0, 1'b1);
    for (int k = 0; k < 17; k++) step(1'b1, DW'(k), 1'b0);
    for (int k = 0; k < 11; k++) step(1'b0, '0, 1'b1);
    chk("flush.pre_cnt", 32'(f0_cnt), 32'd5);
    chk("flush.pre_ovf", 32'(f0_ovf), 32'd1);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    chk("flush.cnt", 32'(f0_cnt), 32'd0);
    chk("flush.empty", 32'(f0_empty), 32'd1);
    chk("flush.ovf", 32'(f0_ovf), 32'd0);
    step(1'b0, '0, 1'b0);
    chk("flush.write_dropped", 32'(f0_cnt), 32'd0);
    for (int k = 0; k < 3; k++) step(1'b1, DW'(8'h20 + k), 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1);
    chk("rst2.cnt", 32'(f0_cnt), 32'd0);
    chk("rst2.flags", 32'({f0_empty, f0_full, f0_ae, f0_af, f0_ovf, f0_udf}), 32'b101000);
    chk("rst2.rd_dat", 32'(f0_rd_dat), 32'd0);
    step(1'b0, '0, 1'b0);

    @(negedge clk);
    cmp_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
